// File: rtl/convolution_pkg.sv
// Shared definitions for the convolution sequencing engine.
// Contents: datapath/address widths, Csize field positions, FSM state codes,
// and the Z write payload struct.
package convolution_pkg;

    localparam int unsigned DATAWIDTH = 32;
    localparam int unsigned SIZEW     = 5;
    localparam int unsigned ADDRW     = 6;

    // Csize register layout: SX in [4:0], SY in [9:5]
    localparam int unsigned CSIZE_SX_LSB = 0;
    localparam int unsigned CSIZE_SY_LSB = 5;

    localparam int unsigned STATEW = 3;
    typedef logic [STATEW-1:0] state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef struct packed {
        logic [ADDRW-1:0]     addr;
        logic [DATAWIDTH-1:0] data;
    } z_wr_t;

endpackage

// File: rtl/convolution_ctrl_if.sv
// Memory-side bus of the convolution engine: X/Y synchronous read ports
// (data valid one cycle after the read strobe) and the Z write port.
// master: engine side (drives addresses, strobes, Z data)
// slave : memory side (returns X/Y read data)
interface convolution_ctrl_if;
    import convolution_pkg::*;

    logic [ADDRW-1:0]     x_addr;
    logic                 x_rd;
    logic [DATAWIDTH-1:0] x_data;
    logic [ADDRW-1:0]     y_addr;
    logic                 y_rd;
    logic [DATAWIDTH-1:0] y_data;
    logic [ADDRW-1:0]     z_addr;
    logic [DATAWIDTH-1:0] z_data;
    logic                 z_we;

    modport master (
        output x_addr, x_rd, y_addr, y_rd, z_addr, z_data, z_we,
        input  x_data, y_data
    );

    modport slave (
        input  x_addr, x_rd, y_addr, y_rd, z_addr, z_data, z_we,
        output x_data, y_data
    );
endinterface

// File: rtl/conv_mac.sv
// Multiply-accumulate for the convolution engine.
// Tracks which cycles carry returning read data (one cycle after an issue)
// and accumulates the truncated product, wrapping modulo 2^DATAWIDTH.
// Ports: clk, rst_a (sync, active-high), en_s (clock enable),
//        clr (zero the accumulator), issue (a read was launched this cycle),
//        x_data/y_data (memory read data), acc (running sum).
module conv_mac
    import convolution_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_a,
    input  logic                 en_s,
    input  logic                 clr,
    input  logic                 issue,
    input  logic [DATAWIDTH-1:0] x_data,
    input  logic [DATAWIDTH-1:0] y_data,
    output logic [DATAWIDTH-1:0] acc
);

    logic                 vld_q;
    logic [DATAWIDTH-1:0] prod_c;

    assign prod_c = DATAWIDTH'(x_data * y_data);

    // Read-valid pipeline and accumulator; both freeze while en_s is low.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            vld_q <= 1'b0;
            acc   <= '0;
        end else if (en_s) begin
            vld_q <= issue;
            if (clr) begin
                acc <= '0;
            end else if (vld_q) begin
                acc <= acc + prod_c;
            end
        end
    end

endmodule

// File: rtl/convolution_ctrl.sv
// Convolution sequencing engine: for n = 0 .. SX+SY-2 computes
// Z[n] = sum_k X[k]*Y[n-k] from the X/Y memories and writes it to Z.
// Ports: clk, rst_a (sync, active-high), en_s (clock enable; strobes gated low),
//        start (sampled in IDLE), size_x/size_y (latched on accepted start),
//        mem (memory bus, master side), busy (any non-IDLE state),
//        done (one-cycle completion pulse).
module convolution_ctrl
    import convolution_pkg::*;
(
    input  logic               clk,
    input  logic               rst_a,
    input  logic               en_s,
    input  logic               start,
    input  logic [SIZEW-1:0]   size_x,
    input  logic [SIZEW-1:0]   size_y,
    convolution_ctrl_if.master mem,
    output logic               busy,
    output logic               done
);

    state_t               state_q, state_d;
    logic [SIZEW-1:0]     sx_q, sx_d;
    logic [SIZEW-1:0]     sy_q, sy_d;
    logic [ADDRW-1:0]     n_q, n_d;
    logic [ADDRW-1:0]     k_q, k_d;
    logic [ADDRW-1:0]     kmax_q, kmax_d;
    logic [ADDRW-1:0]     yaddr_q, yaddr_d;
    logic                 rd_q, rd_d;
    logic                 zwe_q, zwe_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic [DATAWIDTH-1:0] acc;

    // Per-output-index k range: kmin = max(0, n-SY+1), kmax = min(n, SX-1).
    logic [ADDRW:0]   n1_c;
    logic [ADDRW:0]   sy_ext_c;
    logic [ADDRW-1:0] kmin_c;
    logic [ADDRW-1:0] sxm1_c;
    logic [ADDRW-1:0] kmax_c;
    logic [ADDRW-1:0] last_n_c;

    assign n1_c     = {1'b0, n_q} + (ADDRW+1)'(1);
    assign sy_ext_c = (ADDRW+1)'(sy_q);
    assign kmin_c   = (n1_c > sy_ext_c) ? ADDRW'(n1_c - sy_ext_c) : '0;
    assign sxm1_c   = ADDRW'(sx_q) - ADDRW'(1);
    assign kmax_c   = (n_q < sxm1_c) ? n_q : sxm1_c;
    assign last_n_c = ADDRW'(sx_q) + ADDRW'(sy_q) - ADDRW'(2);

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            state_q <= ST_IDLE;
            sx_q    <= '0;
            sy_q    <= '0;
            n_q     <= '0;
            k_q     <= '0;
            kmax_q  <= '0;
            yaddr_q <= '0;
            rd_q    <= 1'b0;
            zwe_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (en_s) begin
            state_q <= state_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            n_q     <= n_d;
            k_q     <= k_d;
            kmax_q  <= kmax_d;
            yaddr_q <= yaddr_d;
            rd_q    <= rd_d;
            zwe_q   <= zwe_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next state; output register values are computed for the state being entered.
    always_comb begin
        state_d = state_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        n_d     = n_q;
        k_d     = k_q;
        kmax_d  = kmax_q;
        yaddr_d = yaddr_q;
        rd_d    = 1'b0;
        zwe_d   = 1'b0;
        done_d  = 1'b0;
        busy_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sx_d = size_x;
                    sy_d = size_y;
                    if ((size_x != '0) && (size_y != '0)) begin
                        state_d = ST_SETUP;
                        n_d     = '0;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_FETCH;
                k_d     = kmin_c;
                kmax_d  = kmax_c;
                yaddr_d = n_q - kmin_c;
                rd_d    = 1'b1;
            end
            ST_FETCH: begin
                if (k_q == kmax_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    k_d     = k_q + ADDRW'(1);
                    yaddr_d = yaddr_q - ADDRW'(1);
                    rd_d    = 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_WRITE;
                zwe_d   = 1'b1;
            end
            ST_WRITE: begin
                if (n_q == last_n_c) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_SETUP;
                    n_d     = n_q + ADDRW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    conv_mac u_mac (
        .clk    (clk),
        .rst_a  (rst_a),
        .en_s   (en_s),
        .clr    (state_q == ST_SETUP),
        .issue  (rd_q),
        .x_data (mem.x_data),
        .y_data (mem.y_data),
        .acc    (acc)
    );

    // Strobes are gated so nothing is issued or written while the clock enable is low.
    assign mem.x_addr = k_q;
    assign mem.y_addr = yaddr_q;
    assign mem.x_rd   = rd_q & en_s;
    assign mem.y_rd   = rd_q & en_s;
    assign mem.z_addr = n_q;
    assign mem.z_data = acc;
    assign mem.z_we   = zwe_q & en_s;
    assign busy       = busy_q;
    assign done       = done_q & en_s;

endmodule
